// File: rtl/kbd_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kbd_tx_pkg
//  Description : Shared definitions for the PS/2 host-to-device transmitter:
//                state encoding, register offsets, status bit positions and
//                the odd-parity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package kbd_tx_pkg;

    // State encoding
    localparam int c_state_w = 3;
    localparam logic [c_state_w-1:0] c_state_idle    = 3'd0;
    localparam logic [c_state_w-1:0] c_state_inhibit = 3'd1;
    localparam logic [c_state_w-1:0] c_state_req     = 3'd2;
    localparam logic [c_state_w-1:0] c_state_xfer    = 3'd3;
    localparam logic [c_state_w-1:0] c_state_ack     = 3'd4;
    localparam logic [c_state_w-1:0] c_state_wrel    = 3'd5;

    // Register offsets
    localparam logic c_addr_ctrl = 1'b0;
    localparam logic c_addr_data = 1'b1;

    // Status register bit positions
    localparam int c_bit_ready  = 0;
    localparam int c_bit_ien    = 1;
    localparam int c_bit_ackerr = 2;
    localparam int c_bit_tmo    = 3;

    // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : kbd_tx_if
//  Description : I/O bus bundle shared by the character devices
//                (en/wr/addr/data_in towards the device, data_out/wt/irq back).
//  Revision    : 1.0 - initial release
// ============================================================================
interface kbd_tx_if;
    logic       en;
    logic       wr;
    logic       addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       wt;
    logic       irq;

    modport master (
        output en, wr, addr, data_in,
        input  data_out, wt, irq
    );

    modport slave (
        input  en, wr, addr, data_in,
        output data_out, wt, irq
    );
endinterface
`default_nettype wire

// File: rtl/kbd_tx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_sync
//  Description : Two-flop synchronizer for the PS/2 clock and data pins plus
//                a falling-edge detector on the synchronized clock.
//                Lines idle high, so the flops reset to 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_sync (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic i_clk_pin,
    input  wire logic i_data_pin,
    output logic      o_clk_sync,
    output logic      o_data_sync,
    output logic      o_clk_fall
);

    logic [1:0] r_clk_ff;
    logic [1:0] r_data_ff;
    logic       r_clk_prev;

    // Synchronize both pins and keep last cycle's synchronized clock for edge detect
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_clk_ff   <= 2'b11;
            r_data_ff  <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_ff   <= {r_clk_ff[0], i_clk_pin};
            r_data_ff  <= {r_data_ff[0], i_data_pin};
            r_clk_prev <= r_clk_ff[1];
        end
    end

    assign o_clk_sync  = r_clk_ff[1];
    assign o_data_sync = r_data_ff[1];
    assign o_clk_fall  = r_clk_prev & ~r_clk_ff[1];

endmodule
`default_nettype wire

// File: rtl/kbd_tx.sv
`default_nettype none
// ============================================================================
//  Module      : kbd_tx
//  Description : PS/2 host-to-device transmitter. Bus responder with a
//                control/status register and a data register; a data write
//                inhibits the clock, requests to send, then shifts the byte,
//                odd parity and stop bit out on device clock falls and checks
//                the device acknowledge. Open-drain line drive.
//  Revision    : 1.0 - initial release
// ============================================================================
module kbd_tx
    import kbd_tx_pkg::*;
#(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 750000
) (
    input  wire logic  clk,
    input  wire logic  reset_n,
    kbd_tx_if.slave    bus,
    input  wire logic  ps2_clk_in,
    input  wire logic  ps2_data_in,
    output logic       ps2_clk_low,
    output logic       ps2_data_low
);

    localparam int c_cnt_max = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_inh_last = c_cnt_w'(INHIBIT_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT_CYC - 1);

    logic w_clk_sync;
    logic w_data_sync;
    logic w_clk_fall;

    ps2_sync u_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clk_pin   (ps2_clk_in),
        .i_data_pin  (ps2_data_in),
        .o_clk_sync  (w_clk_sync),
        .o_data_sync (w_data_sync),
        .o_clk_fall  (w_clk_fall)
    );

    logic [c_state_w-1:0] r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic [3:0]           r_bitcnt, w_bitcnt_nxt;
    logic [7:0]           r_data, w_data_nxt;
    logic                 r_ready, w_ready_nxt;
    logic                 r_ien, w_ien_nxt;
    logic                 r_ackerr, w_ackerr_nxt;
    logic                 r_tmo, w_tmo_nxt;
    logic                 r_clk_low, w_clk_low_nxt;
    logic                 r_data_low, w_data_low_nxt;
    logic                 r_irq;
    logic [7:0]           r_data_out;
    logic [7:0]           w_status;
    logic                 w_wr_ctrl;
    logic                 w_wr_data;
    logic                 w_rd;

    assign w_wr_ctrl = bus.en & bus.wr & (bus.addr == c_addr_ctrl);
    assign w_wr_data = bus.en & bus.wr & (bus.addr == c_addr_data);
    assign w_rd      = bus.en & ~bus.wr;

    // Assemble the status register view
    always_comb begin
        w_status               = 8'h00;
        w_status[c_bit_ready]  = r_ready;
        w_status[c_bit_ien]    = r_ien;
        w_status[c_bit_ackerr] = r_ackerr;
        w_status[c_bit_tmo]    = r_tmo;
    end

    // Next-state, counters, line drive and register updates
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_bitcnt_nxt   = r_bitcnt;
        w_data_nxt     = r_data;
        w_ready_nxt    = r_ready;
        w_ien_nxt      = r_ien;
        w_ackerr_nxt   = r_ackerr;
        w_tmo_nxt      = r_tmo;
        w_clk_low_nxt  = r_clk_low;
        w_data_low_nxt = r_data_low;

        if (w_wr_ctrl) begin
            w_ien_nxt = bus.data_in[c_bit_ien];
        end

        case (r_state)
            c_state_idle: begin
                w_clk_low_nxt  = 1'b0;
                w_data_low_nxt = 1'b0;
                // A write while busy is dropped; ready is only 1 in IDLE
                if (w_wr_data && r_ready) begin
                    w_data_nxt    = bus.data_in;
                    w_ready_nxt   = 1'b0;
                    w_ackerr_nxt  = 1'b0;
                    w_tmo_nxt     = 1'b0;
                    w_cnt_nxt     = '0;
                    w_clk_low_nxt = 1'b1;
                    w_state_nxt   = c_state_inhibit;
                end
            end

            c_state_inhibit: begin
                w_clk_low_nxt  = 1'b1;
                w_data_low_nxt = 1'b0;
                if (r_cnt == c_inh_last) begin
                    // Release clock with data low: the start bit / request to send
                    w_clk_low_nxt  = 1'b0;
                    w_data_low_nxt = 1'b1;
                    w_bitcnt_nxt   = 4'd0;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = c_state_req;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            c_state_req, c_state_xfer, c_state_ack, c_state_wrel: begin
                if (r_cnt == c_tmo_last) begin
                    // Timeout beats any coincident clock fall
                    w_clk_low_nxt  = 1'b0;
                    w_data_low_nxt = 1'b0;
                    w_tmo_nxt      = 1'b1;
                    w_ready_nxt    = 1'b1;
                    w_state_nxt    = c_state_idle;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if ((r_state == c_state_req) || (r_state == c_state_xfer)) begin
                        if (w_clk_fall) begin
                            // r_bitcnt holds the fall number minus one
                            w_bitcnt_nxt = r_bitcnt + 4'd1;
                            w_state_nxt  = c_state_xfer;
                            if (!r_bitcnt[3]) begin
                                w_data_low_nxt = ~r_data[r_bitcnt[2:0]];
                            end else if (r_bitcnt == 4'd8) begin
                                w_data_low_nxt = ~odd_parity(r_data);
                            end else begin
                                w_data_low_nxt = 1'b0;
                                w_state_nxt    = c_state_ack;
                            end
                        end
                    end else if (r_state == c_state_ack) begin
                        if (w_clk_fall) begin
                            w_ackerr_nxt   = w_data_sync;
                            w_data_low_nxt = 1'b0;
                            w_state_nxt    = c_state_wrel;
                        end
                    end else begin
                        if (w_clk_sync && w_data_sync) begin
                            w_ready_nxt = 1'b1;
                            w_state_nxt = c_state_idle;
                        end
                    end
                end
            end

            default: begin
                w_clk_low_nxt  = 1'b0;
                w_data_low_nxt = 1'b0;
                w_ready_nxt    = 1'b1;
                w_state_nxt    = c_state_idle;
            end
        endcase
    end

    // State, datapath and line-drive registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= c_state_idle;
            r_cnt      <= '0;
            r_bitcnt   <= 4'd0;
            r_data     <= 8'h00;
            r_ready    <= 1'b1;
            r_ien      <= 1'b0;
            r_ackerr   <= 1'b0;
            r_tmo      <= 1'b0;
            r_clk_low  <= 1'b0;
            r_data_low <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_data     <= w_data_nxt;
            r_ready    <= w_ready_nxt;
            r_ien      <= w_ien_nxt;
            r_ackerr   <= w_ackerr_nxt;
            r_tmo      <= w_tmo_nxt;
            r_clk_low  <= w_clk_low_nxt;
            r_data_low <= w_data_low_nxt;
            r_irq      <= w_ready_nxt & w_ien_nxt;
        end
    end

    // Registered read data; zero when not being read
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data_out <= 8'h00;
        end else if (w_rd) begin
            r_data_out <= (bus.addr == c_addr_data) ? r_data : w_status;
        end else begin
            r_data_out <= 8'h00;
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.wt        = 1'b0;
    assign bus.irq       = r_irq;
    assign ps2_clk_low   = r_clk_low;
    assign ps2_data_low  = r_data_low;

endmodule
`default_nettype wire
